// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, address/pixel types and arbiter state encoding.
// Imported by the write FIFO and the access arbiter.
package fb_pkg;
  localparam int H_IMAGE    = 240;
  localparam int V_IMAGE    = 320;
  localparam int IMG_PIXELS = H_IMAGE * V_IMAGE;
  localparam int ADDR_W     = $clog2(IMG_PIXELS);
  localparam int COLOR_W    = 3;

  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pixel_t;

  typedef struct packed {
    fb_addr_t addr;
    pixel_t   data;
  } fifo_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  localparam fb_addr_t LAST_ADDR = fb_addr_t'(IMG_PIXELS - 1);

  function automatic logic addr_in_range(input fb_addr_t a);
    return a <= LAST_ADDR;
  endfunction
endpackage

// File: rtl/fb_write_fifo.sv
// Show-ahead synchronous FIFO holding buffered host pixel writes {addr, colour}.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fb_write_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wr_entry,
  output fifo_entry_t rd_entry,
  output logic        full,
  output logic        empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  fifo_entry_t    mem_q [DEPTH];
  logic           do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is legal when the same cycle frees a slot.
  assign do_push  = push && (!full || do_pop);
  assign rd_entry = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry;
  end
endmodule

// File: rtl/fb_access_arbiter.sv
// Single-port frame-buffer scheduler: display reads first, then clear-screen fill,
// then buffered host writes; drives the VGA colour pins two cycles after each read.
module fb_access_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [10:0]        pixel_x,
  input  logic [10:0]        pixel_y,
  input  logic               video_on,
  // Host write port: a write transfers on every cycle with host_valid && host_ready.
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [COLOR_W-1:0] host_data,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               clear_busy,
  output logic               wr_error,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [COLOR_W-1:0] ram_wdata,
  output logic               ram_we,
  input  logic [COLOR_W-1:0] ram_rdata,
  output logic               color_r,
  output logic               color_g,
  output logic               color_b,
  output arb_state_t         dbg_state
);
  arb_state_t  state_q, state_d;
  fb_addr_t    rd_cnt_q, rd_cnt_d;
  fb_addr_t    clr_addr_q, clr_addr_d;
  pixel_t      clr_color_q, clr_color_d;
  logic        clear_busy_q, wr_error_q, wr_error_d;
  logic        rd_d1_q, rd_d2_q;
  pixel_t      pix_q, pix_out;
  logic        rd_cyc, fifo_full, fifo_empty, fifo_pop;
  fifo_entry_t fifo_wr, fifo_rd;

  assign rd_cyc     = video_on && (pixel_x < 11'(H_IMAGE)) && (pixel_y < 11'(V_IMAGE));
  assign host_ready = !fifo_full;
  assign fifo_wr    = {host_addr, host_data};

  fb_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (host_valid && host_ready),
    .pop      (fifo_pop),
    .wr_entry (fifo_wr),
    .rd_entry (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (pixel_y >= 11'(V_IMAGE)) rd_cnt_d = '0;
    else if (rd_cyc) rd_cnt_d = (rd_cnt_q == LAST_ADDR) ? '0 : rd_cnt_q + fb_addr_t'(1);

    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    wr_error_d  = 1'b0;
    fifo_pop    = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    if (rd_cyc) begin
      ram_addr = rd_cnt_q;
    end else if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_q;
      ram_wdata = clr_color_q;
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + fb_addr_t'(1);
      end
    end else if (!fifo_empty) begin
      // Out-of-range entries are consumed without touching the RAM.
      fifo_pop = 1'b1;
      if (addr_in_range(fifo_rd.addr)) begin
        ram_we    = 1'b1;
        ram_addr  = fifo_rd.addr;
        ram_wdata = fifo_rd.data;
      end else begin
        wr_error_d = 1'b1;
      end
    end

    if (state_q == IDLE && clear_req) begin
      state_d     = CLEAR;
      clr_color_d = pixel_t'(clear_color);
      clr_addr_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      clear_busy_q <= 1'b0;
      wr_error_q   <= 1'b0;
      rd_d1_q      <= 1'b0;
      rd_d2_q      <= 1'b0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      clr_addr_q   <= clr_addr_d;
      clr_color_q  <= clr_color_d;
      clear_busy_q <= (state_d == CLEAR);
      wr_error_q   <= wr_error_d;
      rd_d1_q      <= rd_cyc;
      rd_d2_q      <= rd_d1_q;
      pix_q        <= pixel_t'(ram_rdata);
    end
  end

  assign pix_out    = rd_d2_q ? pix_q : '0;
  assign color_r    = pix_out.r;
  assign color_g    = pix_out.g;
  assign color_b    = pix_out.b;
  assign clear_busy = clear_busy_q;
  assign wr_error   = wr_error_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Bench for fb_access_arbiter: RAM model, expected-image model, write scoreboard.
module tb_fb_access_arbiter;
  import fb_pkg::*;
  localparam int IMG = H_IMAGE * V_IMAGE;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] pixel_x, pixel_y;
  logic        video_on, host_valid, host_ready;
  logic [16:0] host_addr;
  logic [2:0]  host_data;
  logic        clear_req;
  logic [2:0]  clear_color;
  logic        clear_busy, wr_error;
  logic [16:0] ram_addr;
  logic [2:0]  ram_wdata, ram_rdata;
  logic        ram_we, color_r, color_g, color_b;
  arb_state_t  dbg_state;

  fb_access_arbiter dut (
    .clock(clock), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data), .clear_req(clear_req),
    .clear_color(clear_color), .clear_busy(clear_busy), .wr_error(wr_error),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .color_r(color_r), .color_g(color_g),
    .color_b(color_b), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1500000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  // external frame-buffer RAM, 1-cycle synchronous read
  logic [2:0] mem [0:IMG-1];
  logic       preload;
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < IMG; i++) mem[i] <= 3'(i % 8);
    end else if (ram_we && ram_addr < 17'(IMG)) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= (ram_addr < 17'(IMG)) ? mem[ram_addr] : 3'd0;
  end

  // reference model and scoreboard
  logic [2:0]  exp_mem [0:IMG-1];
  logic [19:0] exp_q[$];
  int total = 0, bad = 0;
  int clr_writes, clr_bad, clr_nonread, err_pulses, unexpected, wr_in_rd;
  logic [2:0]  clr_color_m;
  logic        mon_en, mon_rd;
  logic [19:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      mon_rd = video_on && (pixel_x < 11'(H_IMAGE)) && (pixel_y < 11'(V_IMAGE));
      if (ram_we) begin
        if (mon_rd) wr_in_rd++;
        if (clear_busy) begin
          if (ram_addr != 17'(clr_writes) || ram_wdata != clr_color_m) clr_bad++;
          clr_writes++;
        end else if (exp_q.size() == 0) begin
          unexpected++;
        end else begin
          mon_e = exp_q.pop_front();
          check("host_write", {12'd0, ram_addr, ram_wdata}, {12'd0, mon_e});
        end
      end
      if (clear_busy && !mon_rd) clr_nonread++;
      if (wr_error) err_pulses++;
      if (host_valid && host_ready && host_addr < 17'(IMG)) exp_q.push_back({host_addr, host_data});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_disp(input logic vo, input int x, input int y);
    video_on = vo;
    pixel_x  = 11'(x);
    pixel_y  = 11'(y);
  endtask

  task automatic host_push(input logic [16:0] a, input logic [2:0] d);
    host_valid = 1'b1;
    host_addr  = a;
    host_data  = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (host_ready) begin
        @(posedge clock);
        #1;
        host_valid = 1'b0;
        return;
      end
    end
    host_valid = 1'b0;
    check("host_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) tick();
    tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [16:0] a;
    logic [2:0]  d, want;
    logic [16:0] a4 [9];
    logic [2:0]  d4 [9];
    logic [2:0]  col_q[$];
    logic        acc, done;
    int          cnt;

    reset = 1'b1; preload = 1'b1; mon_en = 1'b0;
    host_valid = 1'b0; host_addr = '0; host_data = '0;
    clear_req = 1'b0; clear_color = '0;
    set_disp(1'b0, 0, 400);
    clr_writes = 0; clr_bad = 0; clr_nonread = 0; err_pulses = 0;
    unexpected = 0; wr_in_rd = 0; clr_color_m = 3'b010;
    for (int i = 0; i < IMG; i++) exp_mem[i] = 3'(i % 8);
    tick();
    preload = 1'b0;
    @(negedge clock);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_colors", {color_r, color_g, color_b}, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_wr_error", wr_error, 0);
    check("rst_host_ready", host_ready, 1);
    check("rst_state", dbg_state, IDLE);
    tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // two active lines: address = y*240+x, colour two cycles later
    col_q = {3'd0, 3'd0};
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 264; x++) begin
        tick();
        set_disp(x < 256, x, y);
        @(negedge clock);
        if (x < H_IMAGE) begin
          check("rd_addr", ram_addr, y * H_IMAGE + x);
          check("rd_we", ram_we, 0);
        end
        want = col_q.pop_front();
        check("color", {color_r, color_g, color_b}, want);
        col_q.push_back((x < H_IMAGE) ? exp_mem[y * H_IMAGE + x] : 3'd0);
      end
    end

    // single write in horizontal blank, then random writes with random read cycles
    tick();
    set_disp(1'b0, 300, 0);
    host_push(17'd5, 3'b101);
    exp_mem[5] = 3'b101;
    @(negedge clock);
    check("hblank_we", ram_we, 1);
    check("hblank_addr", ram_addr, 5);
    check("hblank_data", ram_wdata, 3'b101);
    for (int n = 0; n < 24; n++) begin
      a = 17'($urandom_range(0, IMG - 1));
      d = 3'($urandom_range(0, 7));
      tick();
      if ($urandom_range(0, 3) == 0) set_disp(1'b1, $urandom_range(0, 239), $urandom_range(0, 319));
      else set_disp(1'b0, 300, 0);
      host_push(a, d);
      exp_mem[a] = d;
    end
    tick();
    set_disp(1'b0, 300, 0);
    wait_drain();

    // FIFO fill during an all-read line; ninth write held, then everything drains
    tick();
    set_disp(1'b0, 0, 400);
    for (int x = 0; x < H_IMAGE; x++) begin
      tick();
      set_disp(1'b1, x, 0);
      host_valid = 1'b1;
      if (x <= 8) begin
        a4[x] = 17'($urandom_range(0, IMG - 1));
        d4[x] = 3'($urandom_range(0, 7));
        host_addr = a4[x];
        host_data = d4[x];
      end
      @(negedge clock);
      if (x == 7) check("ready_before_full", host_ready, 1);
      if (x == 8) check("ready_when_full", host_ready, 0);
      if (x == H_IMAGE - 1) check("ready_line_end", host_ready, 0);
    end
    tick();
    set_disp(1'b0, 300, 0);
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (host_ready) begin
        @(posedge clock);
        #1;
        host_valid = 1'b0;
        acc = 1'b1;
        break;
      end
    end
    host_valid = 1'b0;
    check("ninth_accepted", acc, 1);
    for (int k = 0; k < 9; k++) exp_mem[a4[k]] = d4[k];
    wait_drain();

    // clear screen with a second request and a host write mid-clear
    tick();
    set_disp(1'b0, 300, 400);
    clear_req = 1'b1;
    clear_color = 3'b010;
    for (int i = 0; i < IMG; i++) exp_mem[i] = 3'b010;
    done = 1'b0;
    for (int i = 0; i < 90000; i++) begin
      tick();
      clear_req   = (i == 1000);
      clear_color = (i == 1000) ? 3'b111 : 3'b000;
      host_valid  = (i == 2000);
      host_addr   = 17'd100;
      host_data   = 3'b111;
      if ($urandom_range(0, 31) == 0) set_disp(1'b1, $urandom_range(0, 239), $urandom_range(0, 319));
      else set_disp(1'b0, 300, 400);
      @(negedge clock);
      if (i > 2 && !clear_busy) begin
        done = 1'b1;
        break;
      end
    end
    host_valid = 1'b0;
    exp_mem[100] = 3'b111;
    check("clear_done", done, 1);
    check("clear_nonread_cycles", clr_nonread, IMG);
    check("clear_writes", clr_writes, IMG);
    check("clear_bad_writes", clr_bad, 0);
    tick();
    set_disp(1'b0, 300, 0);
    wait_drain();
    check("ram100_after_clear", mem[100], 3'b111);

    // out-of-range write is dropped with a single error pulse
    host_push(17'(IMG), 3'b011);
    for (int k = 0; k < 5; k++) tick();
    check("wr_error_pulses", err_pulses, 1);
    check("ready_after_drop", host_ready, 1);
    host_push(17'd7, 3'b110);
    exp_mem[7] = 3'b110;
    @(negedge clock);
    check("after_drop_we", ram_we, 1);
    check("after_drop_addr", ram_addr, 7);

    // reset while writes are still queued behind display reads
    tick();
    set_disp(1'b0, 0, 400);
    for (int x = 0; x < 6; x++) begin
      tick();
      set_disp(1'b1, x, 0);
      host_valid = (x < 3);
      host_addr  = 17'($urandom_range(0, IMG - 1));
      host_data  = 3'($urandom_range(0, 7));
    end
    reset = 1'b1;
    host_valid = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("midrst_we", ram_we, 0);
    check("midrst_ready", host_ready, 1);
    check("midrst_busy", clear_busy, 0);
    tick();
    reset = 1'b0;
    set_disp(1'b0, 300, 0);
    for (int k = 0; k < 10; k++) tick();

    cnt = 0;
    for (int i = 0; i < IMG; i++) if (mem[i] !== exp_mem[i]) cnt++;
    check("final_image", cnt, 0);
    check("unexpected_writes", unexpected, 0);
    check("write_in_read", wr_in_rd, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Schedules every access to the single-port 240x320x3-bit frame-buffer RAM.
- Display scan reads always have priority. Host pixel writes are buffered in a small FIFO and drained in free cycles.
- A clear-screen engine fills the whole buffer with one colour.
- Sits between the VGA sync generator, the host loader and the external frame-buffer RAM. Drives color_r/g/b to the VGA pins.

Parameters:
- H_IMAGE, 240, image width in pixels
- V_IMAGE, 320, image height in pixels
- FIFO_DEPTH, 8, host write FIFO entries (power of 2, >=2)
- ADDR_W, $clog2(H_IMAGE*V_IMAGE) = 17, frame-buffer address width
- COLOR_W, 3, pixel width {r,g,b}

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high
- pixel_x  in  11  current column from sync generator
- pixel_y  in  11  current row from sync generator
- video_on  in  1  visible-area flag
- host_valid  in  1  host write request
- host_ready  out  1  FIFO can accept (= !fifo_full)
- host_addr  in  ADDR_W  linear pixel address (y*H_IMAGE+x)
- host_data  in  COLOR_W  pixel colour
- clear_req  in  1  start clear (pulse)
- clear_color  in  COLOR_W  fill colour, sampled with clear_req
- clear_busy  out  1  clear in progress
- wr_error  out  1  one-cycle pulse: out-of-range host write dropped
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  COLOR_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  COLOR_W  RAM read data, 1-cycle synchronous latency
- color_r, color_g, color_b  out  1 each  pixel outputs

Behaviour:
- Reset (async) values:
  - FIFO empty, read counter 0, state IDLE
  - ram_we=0, ram_addr=0, ram_wdata=0
  - colors=0, clear_busy=0, wr_error=0
  - host_ready=1 once the FIFO is empty
- Display read: rd_cyc = video_on & pixel_x<H_IMAGE & pixel_y<V_IMAGE.
  - In an rd_cyc cycle: ram_we=0, ram_addr=rd_cnt, rd_cnt increments.
  - After reading H_IMAGE*V_IMAGE-1, rd_cnt wraps to 0.
  - rd_cnt is forced to 0 while pixel_y>=V_IMAGE (frame resync).
- Output latency: rd_cyc is delayed 2 stages.
  - Colours are registered from ram_rdata; the pixel addressed in cycle N appears on color_* in cycle N+2.
  - If the delayed rd_cyc flag is 0, color_*=0.
  - The sync generator compensates for the 2-cycle delay.
- Non-read cycle arbitration, in priority order:
  - CLEAR write
  - FIFO pop write
  - idle (ram_we=0)
- FIFO: push on host_valid&host_ready.
  - Push and pop in the same cycle is allowed while full; host_ready stays combinational !full only.
  - Pop only in non-read cycles while not clearing.
- Address check at pop: if popped addr >= H_IMAGE*V_IMAGE, the entry is discarded, ram_we=0 and wr_error pulses for 1 cycle.
- State machine:
  - IDLE: on clear_req, latch clear_color, set clr_addr=0, go to CLEAR, clear_busy=1 next cycle.
  - CLEAR: each non-read cycle writes clr_addr with the latched colour, then increments it. After writing H_IMAGE*V_IMAGE-1, return to IDLE with clear_busy=0. Read cycles stall the clear; clr_addr holds.
- Host writes during CLEAR are accepted into the FIFO, never lost, and drained after the clear ends, so they land over the fill.
- clear_req while clear_busy=1 is ignored; it does not restart the clear.
- Reset mid-clear or mid-drain: everything aborts to reset values and FIFO contents are discarded.
- Widths: all address compares are ADDR_W bits unsigned. Counters wrap only by explicit compare, never by overflow.

Decomposition:
- Shared package fb_pkg:
  - H_IMAGE, V_IMAGE, IMG_PIXELS=H_IMAGE*V_IMAGE
  - ADDR_W, COLOR_W
  - typedef fb_addr_t, typedef pixel_t (packed {r,g,b})
  - typedef enum arb_state_t {IDLE, CLEAR}
- Sub-module fb_write_fifo: synchronous FIFO, data = {fb_addr_t, pixel_t}, push/pop/full/empty, async reset.
- Arbitration, read counter, clear engine and output pipeline stay in fb_access_arbiter.

Test Plan:
- Reset, then one active line at y=0 with RAM preloaded with addr[2:0] -> ram_addr 0..239 on consecutive rd_cyc cycles; color_* = addr[2:0] two cycles later; 0 outside x<240.
- Host writes addr=5 data=3'b101 during horizontal blank -> ram_we=1 with ram_addr=5 and ram_wdata=101 in the first non-read cycle; no write during rd_cyc.
- Push 8 writes during the active area with no free cycles -> host_ready=0 after the 8th; the 9th is held, not lost; all 8 drain in order in the next blank.
- clear_req with clear_color=3'b010 -> clear_busy=1 for exactly 76800 non-read cycles; every address written 010; a second clear_req mid-clear is ignored.
- Host write addr=100 data=111 issued mid-clear -> RAM[100]=111 after clear_busy falls.
- Host write addr=76800 -> no RAM write; wr_error pulses one cycle; FIFO is empty afterwards.
